sbus_event_responder: RTL

SBUS_EVENT_RESPONDER -- requirements
Module: sbus_event_responder

---
 rtl/sbus_event_responder.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sbus_event_responder.sv
// Bus-mapped event monitor: counts rising edges of evt_in, queues their
// timestamps in a small FIFO and raises irq while entries or overflow exist.
module sbus_event_responder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        evt_in,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [7:0] A_CTRL    = 8'h00;
  localparam logic [7:0] A_STATUS  = 8'h04;
  localparam logic [7:0] A_EVTCNT  = 8'h08;
  localparam logic [7:0] A_FIFO    = 8'h0C;
  localparam logic [7:0] A_TS      = 8'h10;
  localparam logic [7:0] A_SCRATCH = 8'h14;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic          enable_q, enable_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [31:0]   ts_q, ts_d;
  logic [31:0]   evt_cnt_q, evt_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          evt_prev_q, evt_prev_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic        do_rd, full, empty, evt_hit, clear, pop, push;
  logic [31:0] status, rd_val;

  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    scratch_d  = scratch_q;
    evt_cnt_d  = evt_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rdata_d    = rdata_q;
    ts_d       = ts_q + 32'd1;
    evt_prev_d = evt_in;

    do_rd   = rd & ~wr;
    full    = (count_q == CW'(FIFO_DEPTH));
    empty   = (count_q == '0);
    status  = {21'd0, ovf_q, full, empty, 3'd0, 5'(count_q)};
    evt_hit = evt_in & ~evt_prev_q & enable_q;
    clear   = wr && (addr == A_CTRL) && wdata[1];
    pop     = do_rd && (addr == A_FIFO) && !empty;
    // A full FIFO can still take the event when the same edge frees a slot.
    push    = evt_hit && !clear && (!full || pop);

    case (addr)
      A_CTRL:    rd_val = {29'd0, irq_en_q, 1'b0, enable_q};
      A_STATUS:  rd_val = status;
      A_EVTCNT:  rd_val = evt_cnt_q;
      A_FIFO:    rd_val = empty ? 32'd0 : mem_q[rd_ptr_q];
      A_TS:      rd_val = ts_q;
      A_SCRATCH: rd_val = scratch_q;
      default:   rd_val = 32'd0;
    endcase

    if (do_rd) rdata_d = rd_val;

    if (wr) begin
      case (addr)
        A_CTRL: begin
          enable_d = wdata[0];
          irq_en_d = wdata[2];
        end
        A_SCRATCH: scratch_d = wdata;
        default: ;
      endcase
    end

    if (clear) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      evt_cnt_d = 32'd0;
      ovf_d     = 1'b0;
    end else begin
      if (evt_hit) evt_cnt_d = sat_inc(evt_cnt_q);
      if (evt_hit && full && !pop) ovf_d = 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    irq_d = irq_en_q & (~empty | ovf_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      scratch_q  <= 32'd0;
      ts_q       <= 32'd0;
      evt_cnt_q  <= 32'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      evt_prev_q <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      scratch_q  <= scratch_d;
      ts_q       <= ts_d;
      evt_cnt_q  <= evt_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      evt_prev_q <= evt_prev_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  // Storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ts_q;
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
